instr_fetch: RTL and testbench

Instruction fetch stage placed directly downstream of `pc_reg`. It reads the current PC from the PC register, issues a req/ack read to instruction memory, and presents the fetched word to decode with a valid/ready handshake. It writes the next PC back into `pc_reg`: either sequential or a branch redirect. It owns `pc_reg`'s `i_cs`, `i_oe`, `i_we` and `i_data_in`.

---
 rtl/instr_fetch.sv | 142 ++++++++++++++
 tb/tb_instr_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads PC from pc_reg, fetches over req/ack, hands the word to decode.
// Optional fetch timeout / sticky error state enabled by defining INSTR_FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter int WORD_SIZE = 32,
  parameter int PC_STEP   = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [WORD_SIZE-1:0] i_pc,
  output logic [WORD_SIZE-1:0] o_pc_next,
  output logic                 o_pc_we,
  output logic                 o_pc_cs,
  output logic                 o_pc_oe,
  output logic [WORD_SIZE-1:0] o_imem_addr,
  output logic                 o_imem_req,
  input  logic                 i_imem_ack,
  input  logic [WORD_SIZE-1:0] i_imem_data,
  input  logic                 i_branch_taken,
  input  logic [WORD_SIZE-1:0] i_branch_target,
  output logic [WORD_SIZE-1:0] o_instr,
  output logic [WORD_SIZE-1:0] o_instr_pc,
  output logic                 o_instr_valid,
  input  logic                 i_instr_ready,
  output logic                 o_fetch_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_PCUPD = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
`ifdef INSTR_FETCH_TIMEOUT_EN
  localparam logic [2:0] S_ERR   = 3'd4;
  localparam int CNT_W = $clog2(TIMEOUT);
`endif

  logic [2:0]           state;
  logic                 redir_pend;
  logic                 redir_upd;
  logic [WORD_SIZE-1:0] redir_tgt;
  logic [WORD_SIZE-1:0] pc_next;
  logic [WORD_SIZE-1:0] instr;
  logic [WORD_SIZE-1:0] instr_pc;
  logic                 cs_oe;
`ifdef INSTR_FETCH_TIMEOUT_EN
  logic [CNT_W-1:0]     cnt;
`endif

  // Handshake outputs decode straight from state so an async reset drops them at once.
  assign o_imem_req    = (state == S_REQ);
  assign o_imem_addr   = (state == S_REQ) ? i_pc : '0;
  assign o_pc_we       = (state == S_PCUPD);
  assign o_instr_valid = (state == S_VALID);
  assign o_pc_next     = pc_next;
  assign o_instr       = instr;
  assign o_instr_pc    = instr_pc;
  assign o_pc_cs       = cs_oe;
  assign o_pc_oe       = cs_oe;
`ifdef INSTR_FETCH_TIMEOUT_EN
  assign o_fetch_err   = (state == S_ERR);
`else
  assign o_fetch_err   = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= S_IDLE;
      redir_pend <= 1'b0;
      redir_upd  <= 1'b0;
      redir_tgt  <= '0;
      pc_next    <= '0;
      instr      <= '0;
      instr_pc   <= '0;
      cs_oe      <= 1'b0;
    end else begin
      cs_oe <= 1'b1;
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (i_imem_ack) begin
            state <= S_PCUPD;
            // A redirect arriving with the ack, or parked earlier, discards the fetched word.
            if (i_branch_taken) begin
              pc_next    <= i_branch_target;
              redir_upd  <= 1'b1;
              redir_pend <= 1'b0;
            end else if (redir_pend) begin
              pc_next    <= redir_tgt;
              redir_upd  <= 1'b1;
              redir_pend <= 1'b0;
            end else begin
              instr     <= i_imem_data;
              instr_pc  <= i_pc;
              pc_next   <= i_pc + WORD_SIZE'(PC_STEP);
              redir_upd <= 1'b0;
            end
          end else begin
            if (i_branch_taken) begin
              redir_pend <= 1'b1;
              redir_tgt  <= i_branch_target;
            end
`ifdef INSTR_FETCH_TIMEOUT_EN
            if (cnt == CNT_W'(TIMEOUT - 1)) state <= S_ERR;
`endif
          end
        end
        S_PCUPD: begin
          // A redirect here supersedes the write in flight with a second write of the target.
          if (i_branch_taken) begin
            pc_next   <= i_branch_target;
            redir_upd <= 1'b1;
          end else begin
            state <= redir_upd ? S_REQ : S_VALID;
          end
        end
        S_VALID: begin
          if (i_branch_taken) begin
            pc_next   <= i_branch_target;
            redir_upd <= 1'b1;
            state     <= S_PCUPD;
          end else if (i_instr_ready) begin
            state <= S_REQ;
          end
        end
`ifdef INSTR_FETCH_TIMEOUT_EN
        S_ERR: state <= S_ERR;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef INSTR_FETCH_TIMEOUT_EN
  // Counts cycles spent in S_REQ; cleared in every other state so each entry starts at zero.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)              cnt <= '0;
    else if (state == S_REQ) cnt <= cnt + CNT_W'(1);
    else                     cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural pc_reg; timeout checks follow INSTR_FETCH_TIMEOUT_EN.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_we, pc_cs, pc_oe;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr, instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  instr_fetch #(.WORD_SIZE(32), .PC_STEP(4), .TIMEOUT(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_pc           (pc),
    .o_pc_next      (pc_next),
    .o_pc_we        (pc_we),
    .o_pc_cs        (pc_cs),
    .o_pc_oe        (pc_oe),
    .o_imem_addr    (imem_addr),
    .o_imem_req     (imem_req),
    .i_imem_ack     (imem_ack),
    .i_imem_data    (imem_data),
    .i_branch_taken (branch_taken),
    .i_branch_target(branch_target),
    .o_instr        (instr),
    .o_instr_pc     (instr_pc),
    .o_instr_valid  (instr_valid),
    .i_instr_ready  (instr_ready),
    .o_fetch_err    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment model of pc_reg: captures o_pc_next on the write strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       pc <= '0;
    else if (pc_we) pc <= pc_next;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; imem_ack = 1'b0; imem_data = '0;
    branch_taken = 1'b0; branch_target = '0; instr_ready = 1'b0;

    // Reset state
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_we", {31'd0, pc_we}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_cs", {31'd0, pc_cs}, 32'd0);
    chk("rst_pc_next", pc_next, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);

    // First fetch
    rst = 1'b1;
    tick();
    chk("f1_req", {31'd0, imem_req}, 32'd1);
    chk("f1_addr", imem_addr, 32'd0);
    chk("f1_cs", {31'd0, pc_cs}, 32'd1);
    chk("f1_oe", {31'd0, pc_oe}, 32'd1);
    imem_ack = 1'b1; imem_data = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    chk("f1_we", {31'd0, pc_we}, 32'd1);
    chk("f1_pc_next", pc_next, 32'd4);
    chk("f1_req_drop", {31'd0, imem_req}, 32'd0);
    tick();
    chk("f1_we_once", {31'd0, pc_we}, 32'd0);
    chk("f1_valid", {31'd0, instr_valid}, 32'd1);
    chk("f1_instr", instr, 32'h1234_5678);
    chk("f1_instr_pc", instr_pc, 32'd0);

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_instr", instr, 32'h1234_5678);
      chk("bp_noreq", {31'd0, imem_req}, 32'd0);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("xfer_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("f2_req", {31'd0, imem_req}, 32'd1);
    chk("f2_addr", imem_addr, 32'd4);

    // Second fetch
    imem_ack = 1'b1; imem_data = 32'hAABB_CCDD;
    tick();
    imem_ack = 1'b0;
    chk("f2_pc_next", pc_next, 32'd8);
    tick();
    chk("f2_instr", instr, 32'hAABB_CCDD);
    chk("f2_instr_pc", instr_pc, 32'd4);

    // Redirect in S_VALID
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    tick();
    branch_taken = 1'b0;
    chk("rv_valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("rv_we", {31'd0, pc_we}, 32'd1);
    chk("rv_pc_next", pc_next, 32'h100);
    tick();
    chk("rv_req", {31'd0, imem_req}, 32'd1);
    chk("rv_addr", imem_addr, 32'h100);

    // Redirect during outstanding request
    branch_taken = 1'b1; branch_target = 32'h0000_0200;
    tick();
    branch_taken = 1'b0;
    chk("ro_req_held", {31'd0, imem_req}, 32'd1);
    chk("ro_addr_held", imem_addr, 32'h100);
    tick();
    tick();
    imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("ro_we", {31'd0, pc_we}, 32'd1);
    chk("ro_pc_next", pc_next, 32'h200);
    chk("ro_instr_kept", instr, 32'hAABB_CCDD);
    tick();
    chk("ro_no_valid", {31'd0, instr_valid}, 32'd0);
    chk("ro_addr", imem_addr, 32'h200);

    // Redirect in the same cycle as ack
    imem_ack = 1'b1; imem_data = 32'h1111_1111;
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    imem_ack = 1'b0; branch_taken = 1'b0;
    chk("rs_pc_next", pc_next, 32'hFFFF_FFFC);
    chk("rs_instr_kept", instr, 32'hAABB_CCDD);
    tick();
    chk("rs_addr", imem_addr, 32'hFFFF_FFFC);

    // Wrap-around
    imem_ack = 1'b1; imem_data = 32'h2222_2222;
    tick();
    imem_ack = 1'b0;
    chk("wrap_pc_next", pc_next, 32'd0);
    chk("wrap_we", {31'd0, pc_we}, 32'd1);
    tick();
    chk("wrap_instr", instr, 32'h2222_2222);
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_addr", imem_addr, 32'd0);

    // Ack withheld: first S_REQ cycle is the current one
`ifdef INSTR_FETCH_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_wait_req", {31'd0, imem_req}, 32'd1);
      chk("to_wait_err", {31'd0, fetch_err}, 32'd0);
    end
    tick();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_req_drop", {31'd0, imem_req}, 32'd0);
    chk("to_no_valid", {31'd0, instr_valid}, 32'd0);
    branch_taken = 1'b1; branch_target = 32'h300;
    tick();
    branch_taken = 1'b0;
    chk("to_sticky", {31'd0, fetch_err}, 32'd1);
    chk("to_branch_ignored", {31'd0, pc_we}, 32'd0);
`else
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("nto_req", {31'd0, imem_req}, 32'd1);
      chk("nto_err", {31'd0, fetch_err}, 32'd0);
    end
`endif

    // Mid-operation asynchronous reset
    rst = 1'b0;
    #1;
    chk("mr_req", {31'd0, imem_req}, 32'd0);
    chk("mr_err", {31'd0, fetch_err}, 32'd0);
    chk("mr_we", {31'd0, pc_we}, 32'd0);
    chk("mr_cs", {31'd0, pc_cs}, 32'd0);
    chk("mr_pc_next", pc_next, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
